// File: rtl/sdes_stream_hasher.sv
// Streaming S-DES byte engine (ECB/CBC, encrypt/decrypt) with a per-frame Galois LFSR digest.
// Define SDES_STREAM_LENGTH_EN to fold a 16-bit frame byte count into the digest and expose frame_len.
module sdes_stream_hasher #(
   parameter int          HASH_W    = 32,
   parameter logic [63:0] HASH_POLY = 64'h0000_0000_04C1_1DB7,
   parameter logic [63:0] HASH_SEED = 64'h0000_0000_FFFF_FFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        key,
   input  logic              mode,
   input  logic              chain,
   input  logic [7:0]        iv,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [7:0]        m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic [HASH_W-1:0] digest,
`ifdef SDES_STREAM_LENGTH_EN
   output logic [15:0]       frame_len,
`endif
   output logic              digest_valid
);

   typedef enum logic [1:0] {IDLE, RUN, DIGEST} state_e;

   localparam logic [HASH_W-1:0] POLY = HASH_POLY[HASH_W-1:0];
   localparam logic [HASH_W-1:0] SEED = HASH_SEED[HASH_W-1:0];
   // S-box entries packed two bits each, indexed by {row, col}.
   localparam logic [31:0] S0_TAB = 32'hB7D8_1BB1;
   localparam logic [31:0] S1_TAB = 32'hC613_D2E4;

   function automatic logic [7:0] p8(input logic [9:0] v);
      return {v[4], v[7], v[3], v[6], v[2], v[5], v[0], v[1]};
   endfunction

   function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] sk);
      logic [7:0] x;
      logic [3:0] s;
      x = {d[0], d[3], d[2], d[1], d[2], d[1], d[0], d[3]} ^ sk;
      s = {S0_TAB[{x[7], x[4], x[6], x[5], 1'b0} +: 2],
           S1_TAB[{x[3], x[0], x[2], x[1], 1'b0} +: 2]};
      return {d[7:4] ^ {s[2], s[0], s[1], s[3]}, d[3:0]};
   endfunction

   function automatic logic [7:0] sdes(input logic [7:0] d, input logic [9:0] k, input logic dec);
      logic [9:0] p, ls1, ls3;
      logic [7:0] k1, k2, a;
      p   = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
      ls1 = {p[8:5], p[9], p[3:0], p[4]};
      ls3 = {ls1[7:5], ls1[9:8], ls1[2:0], ls1[4:3]};
      k1  = p8(ls1);
      k2  = p8(ls3);
      a   = fk({d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]}, dec ? k2 : k1);
      a   = fk({a[3:0], a[7:4]}, dec ? k1 : k2);
      return {a[4], a[7], a[5], a[3], a[1], a[6], a[0], a[2]};
   endfunction

   function automatic logic [HASH_W-1:0] hash_byte(input logic [HASH_W-1:0] h, input logic [7:0] b);
      logic [HASH_W-1:0] r;
      logic              fb;
      r = h;
      for (int i = 7; i >= 0; i--) begin
         fb = r[HASH_W-1] ^ b[i];
         r  = {r[HASH_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return r;
   endfunction

   state_e            state_q, state_d;
   logic [9:0]        key_q;
   logic              mode_q, chain_q;
   logic [7:0]        prev_q, prev_d;
   logic [HASH_W-1:0] hash_q, hash_d;
   logic [HASH_W-1:0] digest_q, len_mix;
   logic [7:0]        m_data_q;
   logic              m_valid_q, m_last_q;

   logic       first, accept, mode_e, chain_e;
   logic [9:0] key_e;
   logic [7:0] prev_e, core_in, core_out, byte_out;

   // The first byte of a frame uses the live key/mode/chain/iv; later bytes use the latched copies.
   assign first    = (state_q == IDLE);
   assign key_e    = first ? key   : key_q;
   assign mode_e   = first ? mode  : mode_q;
   assign chain_e  = first ? chain : chain_q;
   assign prev_e   = first ? iv    : prev_q;

   assign s_ready  = (state_q != DIGEST) && (!m_valid_q || m_ready);
   assign accept   = s_valid && s_ready;

   assign core_in  = (chain_e && !mode_e) ? (s_data ^ prev_e) : s_data;
   assign core_out = sdes(core_in, key_e, mode_e);
   assign byte_out = (chain_e && mode_e) ? (core_out ^ prev_e) : core_out;
   assign prev_d   = mode_e ? s_data : byte_out;
   assign hash_d   = hash_byte(hash_q, byte_out);

`ifdef SDES_STREAM_LENGTH_EN
   logic [15:0] cnt_q, cnt_d, len_q;

   assign cnt_d     = first ? 16'd1 : cnt_q + 16'd1;
   assign len_mix   = HASH_W'(cnt_d);
   assign frame_len = len_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         len_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_d;
         if (s_last) len_q <= cnt_d;
      end
   end
`else
   assign len_mix = '0;
`endif

   always_comb begin
      // NOTE: default assigned first so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE, RUN: if (accept) state_d = s_last ? DIGEST : RUN;
         DIGEST:    state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         mode_q  <= 1'b0;
         chain_q <= 1'b0;
         prev_q  <= '0;
         hash_q  <= SEED;
      end else begin
         state_q <= state_d;
         if (accept) begin
            prev_q <= prev_d;
            hash_q <= hash_d;
            if (first) begin
               key_q   <= key;
               mode_q  <= mode;
               chain_q <= chain;
            end
         end else if (state_q == DIGEST) begin
            hash_q <= SEED;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
      end else if (accept) begin
         m_data_q  <= byte_out;
         m_last_q  <= s_last;
         m_valid_q <= 1'b1;
      end else if (m_ready) begin
         m_valid_q <= 1'b0;
      end
   end

   // The final hash is captured on the last byte's edge so digest is already new while DIGEST pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                digest_q <= '0;
      else if (accept && s_last) digest_q <= hash_d ^ len_mix;
   end

   assign m_data       = m_data_q;
   assign m_valid      = m_valid_q;
   assign m_last       = m_last_q;
   assign digest       = digest_q;
   assign digest_valid = (state_q == DIGEST);

endmodule

// File: tb/tb_sdes_stream_hasher.sv
// Self-checking bench: spec-level S-DES/CBC/hash model with a per-cycle compare process plus directed literals.
module tb_sdes_stream_hasher;

   localparam logic [31:0] POLY = 32'h04C1_1DB7;
   localparam logic [31:0] SEED = 32'hFFFF_FFFF;
   localparam logic [9:0]  K    = 10'b1010000010;

   localparam int P10 [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   localparam int P8  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 1, 1};
   localparam int IP  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 1, 1};
   localparam int IPI [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 1, 1};
   localparam int EP  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 1, 1};
   localparam int P4  [10] = '{2, 4, 3, 1, 1, 1, 1, 1, 1, 1};
   localparam int S0 [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
   localparam int S1 [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

   logic        clk, reset;
   logic [9:0]  key;
   logic        mode, chain;
   logic [7:0]  iv, s_data;
   logic        s_valid, s_last, m_ready;
   logic        s_ready, m_valid, m_last, digest_valid;
   logic        s_ready0, m_valid0, m_last0, digest_valid0;
   logic [7:0]  m_data, m_data0;
   logic [31:0] digest, digest0;
`ifdef SDES_STREAM_LENGTH_EN
   logic [15:0] frame_len, frame_len0;
`endif

   sdes_stream_hasher #(.HASH_W(32)) dut (
      .clk(clk), .reset(reset), .key(key), .mode(mode), .chain(chain), .iv(iv),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .digest(digest),
`ifdef SDES_STREAM_LENGTH_EN
      .frame_len(frame_len),
`endif
      .digest_valid(digest_valid)
   );

   sdes_stream_hasher #(.HASH_W(32), .HASH_SEED(64'h0)) dut0 (
      .clk(clk), .reset(reset), .key(key), .mode(mode), .chain(chain), .iv(iv),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready0),
      .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready),
      .digest(digest0),
`ifdef SDES_STREAM_LENGTH_EN
      .frame_len(frame_len0),
`endif
      .digest_valid(digest_valid0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- specification-level model ----------------
   function automatic logic [9:0] perm(input logic [9:0] v, input int n_in, input int n_out, input int pos[10]);
      logic [9:0] r;
      r = '0;
      for (int j = 0; j < n_out; j++) r[n_out-1-j] = v[n_in-pos[j]];
      return r;
   endfunction

   function automatic logic [4:0] rotl5(input logic [4:0] x, input int n);
      logic [9:0] t;
      t = {x, x};
      return t[9-n -: 5];
   endfunction

   function automatic logic [7:0] m_sdes(input logic [7:0] d, input logic [9:0] k, input logic dec);
      logic [9:0] p, t, w;
      logic [7:0] k1, k2, kk, st, e;
      logic [3:0] l, r;
      p  = perm(k, 10, 10, P10);
      t  = {rotl5(p[9:5], 1), rotl5(p[4:0], 1)};
      w  = perm(t, 10, 8, P8);
      k1 = w[7:0];
      t  = {rotl5(p[9:5], 3), rotl5(p[4:0], 3)};
      w  = perm(t, 10, 8, P8);
      k2 = w[7:0];
      w  = perm({2'b00, d}, 8, 8, IP);
      st = w[7:0];
      for (int rd = 0; rd < 2; rd++) begin
         kk = ((rd == 0) != dec) ? k1 : k2;
         l  = st[7:4];
         r  = st[3:0];
         w  = perm({6'b0, r}, 4, 8, EP);
         e  = w[7:0] ^ kk;
         w  = perm({6'b0, 2'(S0[{e[7], e[4]}][{e[6], e[5]}]), 2'(S1[{e[3], e[0]}][{e[2], e[1]}])}, 4, 4, P4);
         l  = l ^ w[3:0];
         st = (rd == 0) ? {r, l} : {l, r};
      end
      w = perm({2'b00, st}, 8, 8, IPI);
      return w[7:0];
   endfunction

   function automatic logic [31:0] m_hash(input logic [31:0] seed, input logic [7:0] q[$]);
      logic [31:0] h;
      logic        fb;
      h = seed;
      foreach (q[n])
         for (int i = 7; i >= 0; i--) begin
            fb = h[31] ^ q[n][i];
            h  = {h[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
         end
      return h;
   endfunction

   logic        exp_mv = 0, exp_ml = 0, exp_dv = 0, exp_ready, acc;
   logic [7:0]  exp_md = 0, mb_out;
   logic [31:0] exp_dig = 0, exp_dig0 = 0, len_x;
   logic [15:0] exp_len = 0;
   bit          in_frame = 0;
   logic [9:0]  f_key;
   logic        f_mode, f_chain;
   logic [7:0]  f_prev;
   logic [7:0]  frame_q[$];
   logic [7:0]  dut_log[$];

   always @(posedge clk) begin
      if (!reset) begin
         exp_mv = 0; exp_ml = 0; exp_md = 0; exp_dv = 0;
         exp_dig = 0; exp_dig0 = 0; exp_len = 0;
         in_frame = 0;
         frame_q.delete();
      end else begin
         exp_ready = !exp_dv && (!exp_mv || m_ready);
         check("s_ready", s_ready, exp_ready);
         check("s_ready_seed0", s_ready0, exp_ready);
         if (m_valid && m_ready) dut_log.push_back(m_data);
         acc    = s_valid && exp_ready;
         exp_dv = 0;
         if (acc) begin
            if (!in_frame) begin
               f_key = key; f_mode = mode; f_chain = chain; f_prev = iv;
            end
            if (!f_chain) mb_out = m_sdes(s_data, f_key, f_mode);
            else if (!f_mode) begin
               mb_out = m_sdes(s_data ^ f_prev, f_key, 1'b0);
               f_prev = mb_out;
            end else begin
               mb_out = m_sdes(s_data, f_key, 1'b1) ^ f_prev;
               f_prev = s_data;
            end
            frame_q.push_back(mb_out);
            exp_mv   = 1;
            exp_md   = mb_out;
            exp_ml   = s_last;
            in_frame = 1;
            if (s_last) begin
               exp_len = 16'(frame_q.size());
`ifdef SDES_STREAM_LENGTH_EN
               len_x = {16'h0, exp_len};
`else
               len_x = 32'h0;
`endif
               exp_dig  = m_hash(SEED, frame_q) ^ len_x;
               exp_dig0 = m_hash(32'h0, frame_q) ^ len_x;
               exp_dv   = 1;
               in_frame = 0;
               frame_q.delete();
            end
         end else if (m_ready) exp_mv = 0;
      end
      #1;
      check("m_valid", m_valid, exp_mv);
      check("m_data", m_data, exp_md);
      check("m_last", m_last, exp_ml);
      check("digest_valid", digest_valid, exp_dv);
      check("digest", digest, exp_dig);
      check("m_data_seed0", m_data0, exp_md);
      check("digest_seed0", digest0, exp_dig0);
`ifdef SDES_STREAM_LENGTH_EN
      check("frame_len", frame_len, exp_len);
`endif
   end

   // ---------------- stimulus ----------------
   logic [7:0] tx[$];
   logic [7:0] ct[$];
   logic [7:0] pt[$];
   logic [7:0] one_q[$];

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends tx[] as one frame; later bytes carry scrambled control inputs that must be ignored.
   task automatic send_frame(input logic [9:0] k, input logic md, input logic ch, input logic [7:0] v,
                             input bit do_last, input int stall_idx);
      int guard;
      for (int i = 0; i < tx.size(); i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = tx[i];
         s_last  = do_last && (i == tx.size() - 1);
         if (i == 0) begin key = k;  mode = md;  chain = ch;  iv = v;  end
         else        begin key = ~k; mode = ~md; chain = ~ch; iv = ~v; end
         if (i == stall_idx) begin
            m_ready = 1'b0;
            #1;
            repeat (4) begin
               check("stall_s_ready", s_ready, 1'b0);
               @(negedge clk);
            end
            m_ready = 1'b1;
            #1;
         end
         guard = 0;
         while (!s_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard == 20) check("s_ready_timeout", s_ready, 1'b1);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   logic [31:0] lx;

   initial begin
      reset = 0; s_valid = 0; s_data = 0; s_last = 0;
      key = 0; mode = 0; chain = 0; iv = 0; m_ready = 1;
`ifdef SDES_STREAM_LENGTH_EN
      lx = 32'h1;
`else
      lx = 32'h0;
`endif
      repeat (3) @(negedge clk);
      reset = 1;

      // Model pinned against hand-computed values.
      check("model_enc_97", m_sdes(8'h97, K, 1'b0), 8'h38);
      check("model_dec_38", m_sdes(8'h38, K, 1'b1), 8'h97);
      one_q = '{8'h01};
      check("model_hash_01", m_hash(32'h0, one_q), 32'h04C1_1DB7);
      one_q = '{8'h00};
      check("model_hash_00", m_hash(32'h0, one_q), 32'h0);

      // ECB encrypt single-byte frame.
      tx = '{8'h97};
      send_frame(K, 1'b0, 1'b0, 8'h00, 1'b1, -1);
      check("t1_m_data", m_data, 8'h38);
      check("t1_m_last", m_last, 1'b1);
      check("t1_m_valid", m_valid, 1'b1);
      check("t1_digest_valid", digest_valid, 1'b1);
      idle(2);

      // ECB decrypt.
      tx = '{8'h38};
      send_frame(K, 1'b1, 1'b0, 8'h00, 1'b1, -1);
      check("t2_m_data", m_data, 8'h97);
      idle(2);

      // Zero seed: outputs 0x00 then 0x01.
      tx = '{m_sdes(8'h00, K, 1'b0)};
      send_frame(K, 1'b1, 1'b0, 8'h00, 1'b1, -1);
      check("t3_digest_00", digest0, 32'h0 ^ lx);
      idle(2);
      tx = '{m_sdes(8'h01, K, 1'b0)};
      send_frame(K, 1'b1, 1'b0, 8'h00, 1'b1, -1);
      check("t3_digest_01", digest0, 32'h04C1_1DB7 ^ lx);
      idle(2);

      // ECB vs CBC with repeated plaintext, then CBC round trip.
      pt = '{8'h41, 8'h41, 8'h41, 8'h42, 8'h42};
      dut_log.delete();
      tx = pt;
      send_frame(K, 1'b0, 1'b0, 8'h00, 1'b1, -1);
      idle(3);
      check("ecb_repeat_a", dut_log[1], dut_log[0]);
      check("ecb_repeat_b", dut_log[4], dut_log[3]);
      dut_log.delete();
      send_frame(K, 1'b0, 1'b1, 8'h5A, 1'b1, -1);
      idle(3);
      check("cbc_differ", dut_log[0] != dut_log[1], 1'b1);
      ct = dut_log;
      dut_log.delete();
      tx = ct;
      send_frame(K, 1'b1, 1'b1, 8'h5A, 1'b1, -1);
      idle(3);
      check("rt_0", dut_log[0], 8'h41);
      check("rt_1", dut_log[1], 8'h41);
      check("rt_2", dut_log[2], 8'h41);
      check("rt_3", dut_log[3], 8'h42);
      check("rt_4", dut_log[4], 8'h42);

      // Output back-pressure mid-frame.
      dut_log.delete();
      tx = '{8'h00, 8'hFF, 8'h13, 8'hC4, 8'h7E, 8'h81};
      send_frame(10'h2F5, 1'b0, 1'b1, 8'hA3, 1'b1, 3);
      idle(3);
      check("stall_beats", dut_log.size(), 6);

      // Reset mid-frame, then a fresh frame.
      tx = '{8'h10, 8'h20, 8'h30};
      send_frame(10'h155, 1'b0, 1'b1, 8'h3C, 1'b0, -1);
      @(negedge clk);
      reset = 0;
      #1;
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_digest", digest, 32'h0);
      check("rst_digest_valid", digest_valid, 1'b0);
      @(negedge clk);
      reset = 1;
      tx = '{8'hAB, 8'hCD, 8'hEF};
      send_frame(10'h0F0, 1'b1, 1'b0, 8'h00, 1'b1, -1);
      idle(3);
`ifdef SDES_STREAM_LENGTH_EN
      check("frame_len_3", frame_len, 16'd3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
